// File: rtl/pipe_pkg.sv
// Shared defaults for the inter-stage pipeline register: field widths, the NOP
// instruction encoding and the occupancy encoding reported on occ.
package pipe_pkg;

    localparam int PC_W_DEF = 16;
    localparam int IR_W_DEF = 16;
    localparam logic [15:0] NOP_IR_DEF = 16'hF000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // SKID is only ever filled behind a valid HEAD, so {0,1} cannot occur.
    function automatic occ_e occ_of(input logic head_v, input logic skid_v);
        case ({head_v, skid_v})
            2'b00:   return OCC_EMPTY;
            2'b11:   return OCC_TWO;
            default: return OCC_ONE;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream stage, the skid register and the
// downstream stage; master drives the upstream side, slave is the register.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int IR_W = IR_W_DEF
) ();

    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [PC_W-1:0] in_pcinc;
    logic [IR_W-1:0] in_ir;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [PC_W-1:0] out_pcinc;
    logic [IR_W-1:0] out_ir;
    logic [1:0]      occ;

    modport master (
        output in_valid, in_pc, in_pcinc, in_ir, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_pcinc, out_ir, occ
    );

    modport slave (
        input  in_valid, in_pc, in_pcinc, in_ir, flush, out_ready,
        output in_ready, out_valid, out_pc, out_pcinc, out_ir, occ
    );

endinterface

// File: rtl/pipe_slot.sv
// One beat of storage: PC, PC+1 and instruction word plus a valid bit.
// Clearing invalidates the beat and parks the IR on NOP; the PC fields hold.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int              PC_W   = PC_W_DEF,
    parameter int              IR_W   = IR_W_DEF,
    parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_IR_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_pcinc,
    input  logic [IR_W-1:0] i_ir,
    output logic            o_valid,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pcinc,
    output logic [IR_W-1:0] o_ir
);

    localparam int W = 2 * PC_W + IR_W;

    logic [W-1:0] r_data;
    logic         r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= {{(2 * PC_W){1'b0}}, NOP_IR};
        end else if (i_clear) begin
            r_valid            <= 1'b0;
            r_data[IR_W-1:0]   <= NOP_IR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= {i_pc, i_pcinc, i_ir};
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_data[W-1 -: PC_W];
    assign o_pcinc = r_data[IR_W +: PC_W];
    assign o_ir    = r_data[IR_W-1:0];

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a two-entry skid buffer: HEAD drives the
// outputs, SKID absorbs one beat of back-pressure so in_ready is a flop.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int              PC_W   = PC_W_DEF,
    parameter int              IR_W   = IR_W_DEF,
    parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_IR_DEF)
) (
    input logic              clk,
    input logic              reset,
    pipe_stage_skid_if.slave bus
);

    logic            w_accept;
    logic            w_pop;
    logic            w_head_load;
    logic            w_head_clear;
    logic            w_head_from_skid;
    logic            w_skid_load;
    logic            w_skid_clear;
    logic            w_head_valid;
    logic            w_skid_valid;
    logic            w_head_v_nxt;
    logic            w_skid_v_nxt;
    logic [PC_W-1:0] w_head_pc_in;
    logic [PC_W-1:0] w_head_pcinc_in;
    logic [IR_W-1:0] w_head_ir_in;
    logic [PC_W-1:0] w_head_pc;
    logic [PC_W-1:0] w_head_pcinc;
    logic [IR_W-1:0] w_head_ir;
    logic [PC_W-1:0] w_skid_pc;
    logic [PC_W-1:0] w_skid_pcinc;
    logic [IR_W-1:0] w_skid_ir;
    occ_e            r_occ;

    assign w_accept = bus.in_valid & ~w_skid_valid;
    assign w_pop    = w_head_valid & bus.out_ready;

    // Flush wins over everything; a pop in the same cycle has already been
    // taken downstream, so clearing both slots is all that is needed.
    always_comb begin
        w_head_load      = 1'b0;
        w_head_clear     = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (bus.flush) begin
            w_head_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_skid_valid) begin
            if (w_pop) begin
                w_head_load      = 1'b1;
                w_head_from_skid = 1'b1;
                w_skid_clear     = 1'b1;
            end
        end else if (w_head_valid) begin
            if (w_pop && w_accept) begin
                w_head_load = 1'b1;
            end else if (w_pop) begin
                w_head_clear = 1'b1;
            end else if (w_accept) begin
                w_skid_load = 1'b1;
            end
        end else if (w_accept) begin
            w_head_load = 1'b1;
        end
    end

    assign w_head_pc_in    = w_head_from_skid ? w_skid_pc    : bus.in_pc;
    assign w_head_pcinc_in = w_head_from_skid ? w_skid_pcinc : bus.in_pcinc;
    assign w_head_ir_in    = w_head_from_skid ? w_skid_ir    : bus.in_ir;

    pipe_slot #(.PC_W(PC_W), .IR_W(IR_W), .NOP_IR(NOP_IR)) u_head (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_pc    (w_head_pc_in),
        .i_pcinc (w_head_pcinc_in),
        .i_ir    (w_head_ir_in),
        .o_valid (w_head_valid),
        .o_pc    (w_head_pc),
        .o_pcinc (w_head_pcinc),
        .o_ir    (w_head_ir)
    );

    pipe_slot #(.PC_W(PC_W), .IR_W(IR_W), .NOP_IR(NOP_IR)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (bus.in_pc),
        .i_pcinc (bus.in_pcinc),
        .i_ir    (bus.in_ir),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_pcinc (w_skid_pcinc),
        .o_ir    (w_skid_ir)
    );

    assign w_head_v_nxt = w_head_load | (w_head_valid & ~w_head_clear);
    assign w_skid_v_nxt = w_skid_load | (w_skid_valid & ~w_skid_clear);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= occ_of(w_head_v_nxt, w_skid_v_nxt);
        end
    end

    assign bus.in_ready  = ~w_skid_valid;
    assign bus.out_valid = w_head_valid;
    assign bus.out_pc    = w_head_pc;
    assign bus.out_pcinc = w_head_pcinc;
    assign bus.out_ir    = w_head_ir;
    assign bus.occ       = r_occ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed handshake scenarios followed by random
// valid/ready/flush traffic, all checked against a two-deep FIFO queue model.
module tb_pipe_stage_skid;

    localparam int              PC_W = 16;
    localparam int              IR_W = 16;
    localparam logic [IR_W-1:0] NOP  = 16'hF000;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pcinc;
        logic [IR_W-1:0] ir;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    beat_t           q[$];
    logic [IR_W-1:0] popped[$];
    int              n_assert = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.PC_W(PC_W), .IR_W(IR_W)) bus ();

    pipe_stage_skid #(.PC_W(PC_W), .IR_W(IR_W), .NOP_IR(16'hF000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [PC_W-1:0] pc, input logic [IR_W-1:0] ir,
                         input logic ord, input logic fl);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_pcinc  = pc + 16'd1;
        bus.in_ir     = ir;
        bus.out_ready = ord;
        bus.flush     = fl;
    endtask

    // One clock of the FIFO model: decide accept/pop from the queue depth and
    // the current inputs, cross the edge, then land on the next falling edge.
    task automatic tick();
        bit    acc;
        bit    pop;
        beat_t b;
        acc = bus.in_valid && (q.size() < 2);
        pop = (q.size() > 0) && bus.out_ready;
        b   = '{pc: bus.in_pc, pcinc: bus.in_pcinc, ir: bus.in_ir};
        if (bus.out_valid && bus.out_ready && !reset) popped.push_back(bus.out_ir);
        @(posedge clk);
        if (reset || bus.flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
        chk({tag, ".occ"}, {30'd0, bus.occ}, q.size());
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk({tag, ".out_ir"}, {16'd0, bus.out_ir}, {16'd0, q[0].ir});
            chk({tag, ".out_pc"}, {16'd0, bus.out_pc}, {16'd0, q[0].pc});
            chk({tag, ".out_pcinc"}, {16'd0, bus.out_pcinc}, {16'd0, q[0].pcinc});
        end else begin
            chk({tag, ".out_ir_nop"}, {16'd0, bus.out_ir}, {16'd0, NOP});
        end
    endtask

    task automatic step(input logic iv, input logic [PC_W-1:0] pc, input logic [IR_W-1:0] ir,
                        input logic ord, input logic fl, input string tag);
        drive(iv, pc, ir, ord, fl);
        tick();
        check_out(tag);
    endtask

    initial begin
        // Reset held with a beat offered (and a flush) upstream.
        drive(1'b1, 16'h0100, 16'h0AAA, 1'b0, 1'b0);
        #2 reset = 1'b1;
        @(negedge clk);
        check_out("rst0");
        chk("rst0.out_pc", {16'd0, bus.out_pc}, 32'd0);
        chk("rst0.out_pcinc", {16'd0, bus.out_pcinc}, 32'd0);
        drive(1'b1, 16'h0100, 16'h0AAA, 1'b0, 1'b1);
        tick();
        check_out("rst1");
        chk("rst1.out_ir", {16'd0, bus.out_ir}, 32'h0000_F000);
        reset = 1'b0;
        step(1'b1, 16'h0100, 16'h0AAA, 1'b0, 1'b0, "first");
        chk("first.out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("first.out_ir", {16'd0, bus.out_ir}, 32'h0000_0AAA);

        // Streaming at full rate with no back-pressure.
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, "drain0");
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'h0200 + 16'(i), 16'h1000 + 16'(i), 1'b1, 1'b0, "stream");
            chk("stream.occ1", {30'd0, bus.occ}, 32'd1);
            chk("stream.ir", {16'd0, bus.out_ir}, 32'h1000 + i);
        end
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, "drain1");
        chk("stream.count", popped.size(), 32'd8);
        for (int i = 0; i < popped.size(); i++)
            chk("stream.order", {16'd0, popped[i]}, 32'h1000 + i);

        // Back-pressure: two beats buffered, third held upstream, then release.
        popped.delete();
        step(1'b1, 16'h0300, 16'h2001, 1'b0, 1'b0, "bp0");
        step(1'b1, 16'h0301, 16'h2002, 1'b0, 1'b0, "bp1");
        step(1'b1, 16'h0302, 16'h2003, 1'b0, 1'b0, "bp2");
        chk("bp.occ2", {30'd0, bus.occ}, 32'd2);
        chk("bp.in_ready0", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0302, 16'h2003, 1'b0, 1'b0, "stall");
            chk("stall.ir", {16'd0, bus.out_ir}, 32'h2001);
        end
        step(1'b1, 16'h0302, 16'h2003, 1'b1, 1'b0, "rel0");
        chk("rel0.in_ready1", {31'd0, bus.in_ready}, 32'd1);
        step(1'b1, 16'h0302, 16'h2003, 1'b1, 1'b0, "rel1");
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, "rel2");
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, "rel3");
        chk("bp.count", popped.size(), 32'd3);
        for (int i = 0; i < popped.size(); i++)
            chk("bp.order", {16'd0, popped[i]}, 32'h2001 + i);

        // Flush at full occupancy with a beat offered the same cycle.
        popped.delete();
        step(1'b1, 16'h0400, 16'h3001, 1'b0, 1'b0, "fl0");
        step(1'b1, 16'h0401, 16'h3002, 1'b0, 1'b0, "fl1");
        step(1'b1, 16'h0402, 16'h3003, 1'b0, 1'b1, "flush");
        chk("flush.occ", {30'd0, bus.occ}, 32'd0);
        chk("flush.ir", {16'd0, bus.out_ir}, 32'h0000_F000);
        chk("flush.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, "postfl0");
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, "postfl1");
        chk("flush.none_out", popped.size(), 32'd0);

        // Asynchronous reset in the middle of a cycle at full occupancy.
        step(1'b1, 16'h0500, 16'h4001, 1'b0, 1'b0, "ar0");
        step(1'b1, 16'h0501, 16'h4002, 1'b0, 1'b0, "ar1");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        q.delete();
        #1;
        check_out("areset");
        chk("areset.out_pc", {16'd0, bus.out_pc}, 32'd0);
        chk("areset.out_ir", {16'd0, bus.out_ir}, 32'h0000_F000);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the queue model.
        for (int c = 0; c < 10000; c++) begin
            step(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                 ($urandom % 3) != 0, ($urandom % 32) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
